// File: rtl/hnf_sram_mask_rd_ctrl_if.sv
// Bundled request, SRAM-read and beat-stream signals of the masked line read controller.
// slave: the controller side; master: the requester, SRAM and beat consumer side.
interface hnf_sram_mask_rd_ctrl_if #(
    parameter int unsigned RAM_ADDR_WIDTH = 10,
    parameter int unsigned RAM_DATA_WIDTH = 512,
    parameter int unsigned RAM_MASK_WIDTH = 16
);
    localparam int unsigned IDX_WIDTH =
        (RAM_MASK_WIDTH > 1) ? $clog2(RAM_MASK_WIDTH) : 1;

    logic                                     REQ_VALID;
    logic                                     REQ_READY;
    logic [RAM_ADDR_WIDTH-1:0]                REQ_ADDR;
    logic [RAM_MASK_WIDTH-1:0]                REQ_BEAT_MASK;
    logic [RAM_ADDR_WIDTH-1:0]                SRAM_ADDR;
    logic [RAM_DATA_WIDTH*RAM_MASK_WIDTH-1:0] SRAM_DATA;
    logic                                     WR_BLOCK;
    logic                                     BEAT_VALID;
    logic                                     BEAT_READY;
    logic [RAM_DATA_WIDTH-1:0]                BEAT_DATA;
    logic [IDX_WIDTH-1:0]                     BEAT_IDX;
    logic                                     BEAT_LAST;

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_BEAT_MASK, SRAM_DATA, BEAT_READY,
        output REQ_READY, SRAM_ADDR, WR_BLOCK, BEAT_VALID, BEAT_DATA, BEAT_IDX, BEAT_LAST
    );

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_BEAT_MASK, SRAM_DATA, BEAT_READY,
        input  REQ_READY, SRAM_ADDR, WR_BLOCK, BEAT_VALID, BEAT_DATA, BEAT_IDX, BEAT_LAST
    );
endinterface

// File: rtl/hnf_sram_mask_rd_ctrl.sv
// Reads one full line from a masked-write SRAM and streams the selected beats, lowest index first.
// Define HNF_SRAM_RD_PIPE_EN for an SRAM with registered read data (adds a WAIT state).
module hnf_sram_mask_rd_ctrl #(
    parameter int unsigned RAM_ADDR_WIDTH = 10,
    parameter int unsigned RAM_DATA_WIDTH = 512,
    parameter int unsigned RAM_MASK_WIDTH = 16
) (
    input logic                    CLK,
    input logic                    RST_N,
    hnf_sram_mask_rd_ctrl_if.slave bus
);
    localparam int unsigned IDX_WIDTH =
        (RAM_MASK_WIDTH > 1) ? $clog2(RAM_MASK_WIDTH) : 1;
    localparam int unsigned LINE_WIDTH = RAM_DATA_WIDTH * RAM_MASK_WIDTH;

`ifdef HNF_SRAM_RD_PIPE_EN
    typedef enum logic [1:0] {StIdle, StRd, StWait, StSend} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRd, StSend} state_e;
`endif

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [RAM_MASK_WIDTH-1:0] mask_q, mask_d;
    logic [LINE_WIDTH-1:0]     line_q, line_d;

    logic                      req_ready;
    logic                      wr_block;
    logic                      beat_valid;
    logic                      beat_last;
    logic                      single_bit;
    logic [IDX_WIDTH-1:0]      beat_idx;
    logic [RAM_DATA_WIDTH-1:0] beat_data;

    // Priority pick of the lowest remaining beat and its line slice.
    always_comb begin
        beat_idx  = '0;
        beat_data = line_q[RAM_DATA_WIDTH-1:0];
        for (int i = int'(RAM_MASK_WIDTH) - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                beat_idx  = IDX_WIDTH'(i);
                beat_data = line_q[i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
            end
        end
    end

    assign single_bit = (mask_q != '0) && ((mask_q & (mask_q - 1'b1)) == '0);

    always_comb begin
        state_d     = state_q;
        sram_addr_d = sram_addr_q;
        mask_d      = mask_q;
        line_d      = line_q;
        req_ready   = 1'b0;
        wr_block    = 1'b0;
        beat_valid  = 1'b0;
        beat_last   = 1'b0;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                // An empty mask is accepted and dropped without touching the SRAM.
                if (bus.REQ_VALID && (bus.REQ_BEAT_MASK != '0)) begin
                    sram_addr_d = bus.REQ_ADDR;
                    mask_d      = bus.REQ_BEAT_MASK;
                    state_d     = StRd;
                end
            end
            StRd: begin
                wr_block = 1'b1;
`ifdef HNF_SRAM_RD_PIPE_EN
                state_d  = StWait;
`else
                line_d   = bus.SRAM_DATA;
                state_d  = StSend;
`endif
            end
`ifdef HNF_SRAM_RD_PIPE_EN
            StWait: begin
                wr_block = 1'b1;
                line_d   = bus.SRAM_DATA;
                state_d  = StSend;
            end
`endif
            StSend: begin
                beat_valid = 1'b1;
                beat_last  = single_bit;
                if (bus.BEAT_READY) begin
                    mask_d = mask_q & (mask_q - 1'b1);
                    if (single_bit) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            sram_addr_q <= '0;
            mask_q      <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            sram_addr_q <= sram_addr_d;
            mask_q      <= mask_d;
            line_q      <= line_d;
        end
    end

    assign bus.REQ_READY  = req_ready;
    assign bus.SRAM_ADDR  = sram_addr_q;
    assign bus.WR_BLOCK   = wr_block;
    assign bus.BEAT_VALID = beat_valid;
    assign bus.BEAT_DATA  = beat_data;
    assign bus.BEAT_IDX   = beat_idx;
    assign bus.BEAT_LAST  = beat_last;

    a_beat_stable: assert property (@(posedge CLK) disable iff (!RST_N)
        (beat_valid && !bus.BEAT_READY) |=>
            (beat_valid && $stable(beat_idx) && $stable(beat_data) && $stable(beat_last)));

    a_last_in_send: assert property (@(posedge CLK) disable iff (!RST_N)
        beat_last |-> beat_valid);
endmodule
